// File: rtl/ctrl_pkg.sv
// Shared opcode, condition and state encodings for the fetch/decode/execute controller.
// The PAUSE state exists only when CTRL_STEP_EN is defined.
package ctrl_pkg;

  localparam logic [3:0] OP_REG  = 4'h0;
  localparam logic [3:0] OP_BR   = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] EXT_CMP = 4'hB;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_AL = 4'hE;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
`ifdef CTRL_STEP_EN
    ST_PAUSE  = 3'd4,
`endif
    ST_HALT   = 3'd3
  } state_e;

  function automatic logic [15:0] sext8_16(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic logic [31:0] sext8_32(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational instruction decoder: IR + latched zero flag -> datapath
// control bundle plus branch/halt classification.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [15:0] ir,
  input  logic        z,
  output logic [7:0]  alu_op,
  output logic [7:0]  muxes,
  output logic [15:0] regs_en,
  output logic [15:0] imm,
  output logic        is_alu,
  output logic        is_branch,
  output logic        br_taken,
  output logic        is_halt
);

  logic [3:0] op;
  logic [3:0] rd;
  logic [3:0] ext;
  logic [3:0] rsrc;

  assign op   = ir[15:12];
  assign rd   = ir[11:8];
  assign ext  = ir[7:4];
  assign rsrc = ir[3:0];

  always_comb begin
    // NOTE: every output gets a default before the branches so no path leaves one unassigned (no latches).
    alu_op    = 8'h00;
    muxes     = 8'h00;
    regs_en   = 16'h0000;
    imm       = 16'h0000;
    is_alu    = 1'b0;
    is_branch = 1'b0;
    br_taken  = 1'b0;
    is_halt   = 1'b0;

    if (op == OP_REG) begin
      is_alu  = 1'b1;
      alu_op  = {4'h0, ext};
      muxes   = {rd, rsrc};
      regs_en = (ext == EXT_CMP) ? 16'h0000 : (16'h0001 << rd);
    end else if (!op[3]) begin
      is_alu  = 1'b1;
      alu_op  = {op, 4'h0};
      muxes   = {rd, 4'h0};
      imm     = sext8_16(ir[7:0]);
      regs_en = 16'h0001 << rd;
    end else if (op == OP_BR) begin
      // For branches the Rdest field carries the condition code.
      is_branch = 1'b1;
      case (rd)
        COND_EQ: br_taken = z;
        COND_NE: br_taken = !z;
        COND_AL: br_taken = 1'b1;
        default: br_taken = 1'b0;
      endcase
    end else if (op == OP_HALT) begin
      is_halt = 1'b1;
    end
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Fetch/decode/execute controller: owns the FSM, PC and zero flag; all outputs registered.
// Optional single-step mode (step input, PAUSE state) is enabled by defining CTRL_STEP_EN.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
`ifdef CTRL_STEP_EN
  input  logic              step,
`endif
  output logic              instr_req,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_ack,
  input  logic [15:0]       instr_data,
  input  logic              zero_in,
  output logic [7:0]        alu_op,
  output logic [7:0]        muxes,
  output logic [15:0]       regs_en,
  output logic [15:0]       imm,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic              z_q, z_d;
  logic              req_q, req_d;
  logic [7:0]        alu_op_q, alu_op_d;
  logic [7:0]        muxes_q, muxes_d;
  logic [15:0]       regs_en_q, regs_en_d;
  logic [15:0]       imm_q, imm_d;
  logic              halted_q, halted_d;
`ifdef CTRL_STEP_EN
  logic              step_prev_q, step_prev_d;
`endif

  logic [7:0]  dec_alu_op;
  logic [7:0]  dec_muxes;
  logic [15:0] dec_regs_en;
  logic [15:0] dec_imm;
  logic        dec_is_alu;
  logic        dec_is_branch;
  logic        dec_br_taken;
  logic        dec_is_halt;

  ctrl_decode u_decode (
    .ir        (ir_q),
    .z         (z_q),
    .alu_op    (dec_alu_op),
    .muxes     (dec_muxes),
    .regs_en   (dec_regs_en),
    .imm       (dec_imm),
    .is_alu    (dec_is_alu),
    .is_branch (dec_is_branch),
    .br_taken  (dec_br_taken),
    .is_halt   (dec_is_halt)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    z_d         = z_q;
    req_d       = 1'b0;
    alu_op_d    = 8'h00;
    muxes_d     = 8'h00;
    regs_en_d   = 16'h0000;
    imm_d       = 16'h0000;
    halted_d    = 1'b0;
`ifdef CTRL_STEP_EN
    step_prev_d = step;
`endif

    case (state_q)
      ST_FETCH: begin
        // The request rises one cycle after reset, so an ack can only be taken once it is visible.
        if (req_q && instr_ack) begin
          ir_d    = instr_data;
          state_d = ST_DECODE;
        end else begin
          req_d = 1'b1;
        end
      end
      ST_DECODE: begin
        // Outputs are loaded here so they appear for exactly the EXEC cycle.
        alu_op_d  = dec_alu_op;
        muxes_d   = dec_muxes;
        regs_en_d = dec_regs_en;
        imm_d     = dec_imm;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        if (dec_is_halt) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else begin
          if (dec_is_alu) begin
            z_d = zero_in;
          end
          if (dec_is_branch && dec_br_taken) begin
            pc_d = pc_q + ADDR_W'(sext8_32(ir_q[7:0]));
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
`ifdef CTRL_STEP_EN
          state_d = ST_PAUSE;
`else
          state_d = ST_FETCH;
          req_d   = 1'b1;
`endif
        end
      end
`ifdef CTRL_STEP_EN
      ST_PAUSE: begin
        if (step && !step_prev_q) begin
          state_d = ST_FETCH;
          req_d   = 1'b1;
        end
      end
`endif
      ST_HALT: begin
        halted_d = 1'b1;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= 16'h0000;
      z_q         <= 1'b0;
      req_q       <= 1'b0;
      alu_op_q    <= 8'h00;
      muxes_q     <= 8'h00;
      regs_en_q   <= 16'h0000;
      imm_q       <= 16'h0000;
      halted_q    <= 1'b0;
`ifdef CTRL_STEP_EN
      step_prev_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      z_q         <= z_d;
      req_q       <= req_d;
      alu_op_q    <= alu_op_d;
      muxes_q     <= muxes_d;
      regs_en_q   <= regs_en_d;
      imm_q       <= imm_d;
      halted_q    <= halted_d;
`ifdef CTRL_STEP_EN
      step_prev_q <= step_prev_d;
`endif
    end
  end

  assign instr_req  = req_q;
  assign instr_addr = req_q ? pc_q : '0;
  assign alu_op     = alu_op_q;
  assign muxes      = muxes_q;
  assign regs_en    = regs_en_q;
  assign imm        = imm_q;
  assign halted     = halted_q;

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
Fetch/decode/execute controller for the 16-register, 16-bit ALU datapath. It replaces hard-wired demo sequences with a program held in instruction memory. Each cycle it drives the datapath control bundle: alu_op, muxes, regs_en and imm. It keeps a PC and a latched zero flag, and supports register ALU ops, immediate ALU ops, conditional branches and halt.

Parameters:
ADDR_W, 16, width of PC / instr_addr
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
instr_req  out  1  fetch request; held until instr_ack
instr_addr  out  ADDR_W  fetch address (= PC); stable while instr_req=1
instr_ack  in  1  memory accepts; instr_data valid same cycle
instr_data  in  16  instruction word
zero_in  in  1  ALU zero flag for the current EXEC result
alu_op  out  8  ALU opcode to datapath
muxes  out  8  [7:4] A-operand reg select, [3:0] B-operand reg select
regs_en  out  16  one-hot register write enable
imm  out  16  sign-extended immediate
halted  out  1  high in HALT state

Interface (already decided): reset reset, synchronous, active-low; clock clk.

Behaviour:
- Instruction formats:
  - reg ALU: [15:12]=0, [11:8]=Rdest, [7:4]=ext, [3:0]=Rsrc.
  - imm ALU: [15:12]=op with op[3]=0 and op!=0, [11:8]=Rdest, [7:0]=imm8.
  - branch: op=4'hC, [11:8]=cond, [7:0]=signed disp.
  - halt: op=4'hF.
  - Any other op is a NOP.
- States: FETCH -> DECODE -> EXEC -> FETCH; HALT is absorbing.
- Reset: applies on a clk edge with reset=0, wins over everything, including a mid-handshake or halted state.
  - Next state FETCH, PC=RESET_PC, IR=0, Z=0.
  - All outputs 0 while reset is asserted and in the cycle after.
- FETCH: instr_req=1, instr_addr=PC. On instr_ack=1, IR<=instr_data and go to DECODE; otherwise stay. instr_ack while instr_req=0 is ignored.
- DECODE: 1 cycle, all control outputs 0. Zero-wait memory gives 3 cycles per instruction.
- EXEC: control outputs are valid for exactly this one cycle. In all other states alu_op=0, muxes=0, regs_en=0, imm=0.
  - reg ALU:
    - alu_op={4'h0,ext}, muxes={Rdest,Rsrc}, regs_en=1<<Rdest.
    - Exception: ext=4'hB (CMP) writes no register, so regs_en=0.
    - Z<=zero_in; PC<=PC+1.
  - imm ALU:
    - alu_op={op,4'h0}, muxes={Rdest,4'h0}, imm=sext(imm8), regs_en=1<<Rdest.
    - Z<=zero_in; PC<=PC+1.
  - branch:
    - Taken when cond 4'h0 and Z=1, cond 4'h1 and Z=0, or cond 4'hE; any other cond is never taken.
    - Taken: PC<=PC+sext(disp), modulo 2^ADDR_W. Not taken: PC<=PC+1.
    - Z unchanged; regs_en=0.
  - NOP: PC<=PC+1, all outputs 0.
  - halt: next state HALT, PC unchanged.
- HALT: halted=1, instr_req=0, all control outputs 0; left only via reset.
- PC wraps from 2^ADDR_W-1 to 0 without error.

Optional Feature:
CTRL_STEP_EN:
- Defined:
  - Adds input step (1 bit).
  - After each EXEC the FSM enters a PAUSE state, with all outputs 0.
  - PAUSE moves to FETCH on a cycle where step=1. A step held high advances only one instruction per rising level.
  - Reset exits PAUSE to FETCH.
- Undefined: no step port and no PAUSE state; EXEC goes straight to FETCH.

Decomposition:
- Package ctrl_pkg holds:
  - opcode constants: OP_REG=4'h0, OP_BR=4'hC, OP_HALT=4'hF;
  - ext constant EXT_CMP=4'hB;
  - branch cond constants: EQ=0, NE=1, AL=E;
  - state encoding constants.
- One combinational sub-module, ctrl_decode: IR + Z -> alu_op, muxes, regs_en, imm, is_branch, br_taken, is_halt.
- The FSM, PC and Z flag stay in ctrl_sequencer.

Test Plan:
- Reset then zero-wait memory, program {16'h5110 (ADDI R1,#16), 16'h0251 (ADD R2,R1)}:
  - EXEC 1: alu_op=50, muxes=10, imm=0010, regs_en=0002.
  - EXEC 2: alu_op=05, muxes=21, regs_en=0004.
  - PC=2 after 6 cycles.
- instr_ack delayed 3 cycles: instr_req and instr_addr held stable for 4 cycles; no EXEC until DECODE follows the ack.
- Branch:
  - zero_in=1 during a CMP (16'h01B2): regs_en=0, Z=1.
  - Then BEQ disp=-2 (16'hC0FE) at PC=5: PC becomes 3.
  - Same sequence with zero_in=0: PC becomes 6.
- Halt and reset:
  - 16'hF000: halted=1, instr_req=0 for 20 cycles.
  - reset=0 for one cycle: PC=0, FETCH resumes.
- Reset asserted during FETCH with instr_ack arriving the same cycle: IR is not loaded, PC=RESET_PC, outputs 0.
- Wrap: ADDR_W=4, PC=15, NOP executed -> PC=0.
- With CTRL_STEP_EN: no fetch until step pulses; one instruction per pulse.
